// File: rtl/ddr_req_arbiter_if.sv
// MIG 7-series app-port bundle between the request arbiter (master) and the MIG user interface (slave).
interface ddr_req_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic [ADDR_W-1:0]   app_addr;
    logic [2:0]          app_cmd;
    logic                app_en;
    logic                app_rdy;
    logic [DATA_W-1:0]   app_wdf_data;
    logic                app_wdf_wren;
    logic                app_wdf_end;
    logic [DATA_W/8-1:0] app_wdf_mask;
    logic                app_wdf_rdy;
    logic [DATA_W-1:0]   app_rd_data;
    logic                app_rd_data_valid;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_wren, app_wdf_end, app_wdf_mask,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid
    );
endinterface

// File: rtl/ddr_req_arbiter.sv
// Shares the MIG app port among PSC (0), DSC (1) and L2 (2), one 128-bit transaction per grant.
// Define DDR_ARB_RR_EN for round-robin arbitration; otherwise fixed priority PSC > DSC > L2.
module ddr_req_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int NREQ   = 3
) (
    input  logic                   clk_166M66,
    input  logic                   mcu_sys_rst,
    input  logic                   i_init_calib_complete,
    input  logic [NREQ-1:0]        i_req,
    input  logic [NREQ-1:0]        i_rw,
    input  logic [NREQ*ADDR_W-1:0] i_addr,
    input  logic [NREQ*DATA_W-1:0] i_wdata,
    output logic [NREQ-1:0]        o_gnt,
    output logic [NREQ-1:0]        o_done,
    output logic [DATA_W-1:0]      o_rdata,
    output logic                   o_busy,
    ddr_req_arbiter_if.master      app
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {IDLE, WDATA, CMD, RDWAIT, DONE} state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    win;
    logic                found;
    logic                grant_ok;
    logic [NREQ-1:0]     gnt_q;
    logic                rw_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;

`ifdef DDR_ARB_RR_EN
    logic [IDX_W-1:0]    rr_ptr;

    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && i_req[(int'(rr_ptr) + k) % NREQ]) begin
                win   = IDX_W'((int'(rr_ptr) + k) % NREQ);
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        win   = '0;
        found = 1'b0;
        // Walk downwards so the lowest requesting index is the last to be written.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                win   = IDX_W'(k);
                found = 1'b1;
            end
        end
    end
`endif

    assign grant_ok = i_init_calib_complete && found;

    // NOTE: sequential state uses non-blocking assignments; the reset is synchronous, sampled on the clock edge.
    always_ff @(posedge clk_166M66) begin
        if (mcu_sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_ok) state_nxt = i_rw[win] ? WDATA : CMD;
            WDATA:   if (app.app_wdf_rdy) state_nxt = CMD;
            CMD:     if (app.app_rdy) state_nxt = rw_q ? DONE : RDWAIT;
            RDWAIT:  if (app.app_rd_data_valid) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the datapath registers are reset as well so that every output reads 0 straight after reset.
    always_ff @(posedge clk_166M66) begin
        if (mcu_sys_rst) begin
            gnt_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef DDR_ARB_RR_EN
            rr_ptr  <= '0;
`endif
        end else begin
            if (state == IDLE && grant_ok) begin
                gnt_q   <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                rw_q    <= i_rw[win];
                addr_q  <= i_addr[win*ADDR_W +: ADDR_W];
                wdata_q <= i_wdata[win*DATA_W +: DATA_W];
`ifdef DDR_ARB_RR_EN
                rr_ptr  <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
`endif
            end else if (state == DONE) begin
                gnt_q <= '0;
            end
            if (state == RDWAIT && app.app_rd_data_valid) begin
                rdata_q <= app.app_rd_data;
            end
        end
    end

    always_comb begin
        app.app_en       = (state == CMD);
        app.app_cmd      = (state == CMD && !rw_q) ? 3'b001 : 3'b000;
        app.app_wdf_wren = (state == WDATA);
        app.app_wdf_end  = (state == WDATA);
        o_done           = gnt_q & {NREQ{state == DONE}};
        o_busy           = (state != IDLE);
    end

    assign app.app_addr     = addr_q;
    assign app.app_wdf_data = wdata_q;
    assign app.app_wdf_mask = '0;
    assign o_gnt            = gnt_q;
    assign o_rdata          = rdata_q;
endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Directed self-checking bench for ddr_req_arbiter; expectations follow DDR_ARB_RR_EN when it is defined.
module tb_ddr_req_arbiter;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int NREQ   = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   calib;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        rw;
    logic [NREQ*ADDR_W-1:0] addr;
    logic [NREQ*DATA_W-1:0] wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic [DATA_W-1:0]      rdata;
    logic                   busy;

    int checks   = 0;
    int failures = 0;

    ddr_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) app_bus ();

    ddr_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREQ(NREQ)) dut (
        .clk_166M66            (clk),
        .mcu_sys_rst           (rst),
        .i_init_calib_complete (calib),
        .i_req                 (req),
        .i_rw                  (rw),
        .i_addr                (addr),
        .i_wdata               (wdata),
        .o_gnt                 (gnt),
        .o_done                (done),
        .o_rdata               (rdata),
        .o_busy                (busy),
        .app                   (app_bus.master)
    );

    always #3 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges and settle 1 ns past the last one.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " gnt"},   gnt, '0);
        check({tag, " done"},  done, '0);
        check({tag, " busy"},  busy, '0);
        check({tag, " en"},    app_bus.app_en, '0);
        check({tag, " wren"},  app_bus.app_wdf_wren, '0);
        check({tag, " end"},   app_bus.app_wdf_end, '0);
        check({tag, " cmd"},   app_bus.app_cmd, '0);
        check({tag, " addr"},  app_bus.app_addr, '0);
        check({tag, " wdf"},   app_bus.app_wdf_data, '0);
        check({tag, " mask"},  app_bus.app_wdf_mask, '0);
        check({tag, " rdata"}, rdata, '0);
    endtask

    logic [DATA_W-1:0] pat_a5;
    logic [DATA_W-1:0] pat_l2;
    logic [NREQ-1:0]   exp_gnt [6];

    initial begin
        pat_a5 = {16{8'hA5}};
        pat_l2 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        rst = 1'b1; calib = 1'b0; req = '0; rw = '0; addr = '0; wdata = '0;
        app_bus.app_rdy = 1'b0; app_bus.app_wdf_rdy = 1'b0;
        app_bus.app_rd_data = '0; app_bus.app_rd_data_valid = 1'b0;
        tick(2);
        check_all_zero("reset");

        // 1: no grant while calibration is incomplete
        rst = 1'b0; req = 3'b111;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("nocal gnt", gnt, '0);
            check("nocal en", app_bus.app_en, '0);
            check("nocal busy", busy, '0);
        end
        req = '0; calib = 1'b1;
        tick();

        // 2: PSC read, minimum latency
        req = 3'b001; rw = 3'b000; addr[0 +: ADDR_W] = 28'h0000100; app_bus.app_rdy = 1'b1;
        tick();
        check("rd T1 gnt", gnt, 3'b001);
        check("rd T1 en", app_bus.app_en, 1'b1);
        check("rd T1 cmd", app_bus.app_cmd, 3'b001);
        check("rd T1 addr", app_bus.app_addr, 28'h0000100);
        check("rd T1 busy", busy, 1'b1);
        tick();
        check("rd T2 en", app_bus.app_en, 1'b0);
        check("rd T2 done", done, 3'b000);
        check("rd T2 gnt", gnt, 3'b001);
        app_bus.app_rd_data = pat_a5; app_bus.app_rd_data_valid = 1'b1;
        tick();
        check("rd T3 done", done, 3'b001);
        check("rd T3 gnt", gnt, 3'b001);
        check("rd T3 rdata", rdata, pat_a5);
        app_bus.app_rd_data_valid = 1'b0; app_bus.app_rd_data = '0; req = '0;
        tick();
        check("rd idle done", done, 3'b000);
        check("rd idle gnt", gnt, 3'b000);
        check("rd idle busy", busy, 1'b0);
        check("rd hold rdata", rdata, pat_a5);

        // 3: DSC write with the write FIFO stalled
        req = 3'b010; rw = 3'b010; addr[ADDR_W +: ADDR_W] = 28'h0ABCDE0;
        wdata[DATA_W +: DATA_W] = 128'h1234; app_bus.app_rdy = 1'b0; app_bus.app_wdf_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("wr wren", app_bus.app_wdf_wren, 1'b1);
            check("wr end", app_bus.app_wdf_end, 1'b1);
            check("wr en", app_bus.app_en, 1'b0);
            check("wr gnt", gnt, 3'b010);
            check("wr wdf data", app_bus.app_wdf_data, 128'h1234);
            if (i == 3) app_bus.app_wdf_rdy = 1'b1;
        end
        tick();
        app_bus.app_wdf_rdy = 1'b0;
        check("wr cmd wren", app_bus.app_wdf_wren, 1'b0);
        check("wr cmd en", app_bus.app_en, 1'b1);
        check("wr cmd cmd", app_bus.app_cmd, 3'b000);
        check("wr cmd addr", app_bus.app_addr, 28'h0ABCDE0);
        tick();
        check("wr cmd wait en", app_bus.app_en, 1'b1);
        app_bus.app_rdy = 1'b1;
        tick();
        check("wr done", done, 3'b010);
        check("wr done en", app_bus.app_en, 1'b0);
        check("wr rdata kept", rdata, pat_a5);
        req = '0;
        tick();
        check("wr idle done", done, 3'b000);
        check("wr idle gnt", gnt, 3'b000);

        // 4: all three requesting continuously, starting from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            addr[k*ADDR_W +: ADDR_W] = 28'h0000010 * (k + 1);
            wdata[k*DATA_W +: DATA_W] = 128'h100 + k;
        end
`ifdef DDR_ARB_RR_EN
        exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
        exp_gnt = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
        req = 3'b111; rw = 3'b111; app_bus.app_wdf_rdy = 1'b1; app_bus.app_rdy = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            check("arb gnt", gnt, exp_gnt[t]);
            check("arb wren", app_bus.app_wdf_wren, 1'b1);
            tick();
            check("arb addr",
                  app_bus.app_addr,
                  (exp_gnt[t] == 3'b001) ? 28'h10 : (exp_gnt[t] == 3'b010) ? 28'h20 : 28'h30);
            tick();
            check("arb done", done, exp_gnt[t]);
            tick();
            check("arb idle busy", busy, 1'b0);
        end
        req = '0; app_bus.app_wdf_rdy = 1'b0;
        tick();

        // 5: L2 read with the command port stalled; request dropped mid-wait
        req = 3'b100; rw = 3'b000; addr[2*ADDR_W +: ADDR_W] = 28'h0FEDCB0; app_bus.app_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("l2 en", app_bus.app_en, 1'b1);
            check("l2 gnt", gnt, 3'b100);
            check("l2 cmd", app_bus.app_cmd, 3'b001);
            if (i == 1) begin
                app_bus.app_rd_data = 128'hBAD; app_bus.app_rd_data_valid = 1'b1;
            end else begin
                app_bus.app_rd_data_valid = 1'b0;
            end
            if (i == 2) req = 3'b000;
            if (i == 5) app_bus.app_rdy = 1'b1;
        end
        tick();
        check("l2 wait en", app_bus.app_en, 1'b0);
        check("l2 stray valid", rdata, '0);
        app_bus.app_rd_data = pat_l2; app_bus.app_rd_data_valid = 1'b1;
        tick();
        check("l2 done", done, 3'b100);
        check("l2 rdata", rdata, pat_l2);
        app_bus.app_rd_data_valid = 1'b0;
        tick();
        check("l2 done once", done, 3'b000);
        tick();
        check("l2 no regrant", gnt, 3'b000);

        // 6: reset while waiting for read data, then a normal PSC read
        req = 3'b001; rw = 3'b000; addr[0 +: ADDR_W] = 28'h0000200; app_bus.app_rdy = 1'b1;
        tick(2);
        check("rst pre busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        check_all_zero("rst rdwait");
        rst = 1'b0;
        tick();
        check("post rst gnt", gnt, 3'b001);
        check("post rst addr", app_bus.app_addr, 28'h0000200);
        tick();
        app_bus.app_rd_data = pat_a5; app_bus.app_rd_data_valid = 1'b1;
        tick();
        check("post rst done", done, 3'b001);
        check("post rst rdata", rdata, pat_a5);
        app_bus.app_rd_data_valid = 1'b0; req = '0;
        tick();
        check("post rst idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
